// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions used by the receiver and transmitter.
// RS232_RX_PARITY_EN adds the PARITY receiver state.
package rs232_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
`ifdef RS232_RX_PARITY_EN
      , PARITY
`endif
   } rx_state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Terminal count of the per-bit counter: half a bit for the start sample,
   // a full bit for every later sample.
   function automatic int sample_offset(input int clks_per_bit, input bit half);
      return half ? (clks_per_bit / 2 - 1) : (clks_per_bit - 1);
   endfunction

endpackage

// File: rtl/rs232_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset and
// selectable reset value.
module rs232_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rs232_receiver.sv
// RS-232 serial receiver, LSB first, one stop bit, mid-bit sampling.
// Define RS232_RX_PARITY_EN for an even parity bit and the parity_err output.
module rs232_receiver
   import rs232_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
`ifdef RS232_RX_PARITY_EN
   , output logic               parity_err
`endif
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(sample_offset(CLKS_PER_BIT, 1'b1));
   localparam logic [CW-1:0] BIT_LAST  = CW'(sample_offset(CLKS_PER_BIT, 1'b0));
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   logic                 rxs;
   rx_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] data_d;
   logic                 valid_d, ferr_d;
`ifdef RS232_RX_PARITY_EN
   logic                 par_ok_q, par_ok_d;
   logic                 perr_d;
`endif

   rs232_sync2 #(.RESET_VAL(IDLE_LEVEL)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rxs)
   );

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
`ifdef RS232_RX_PARITY_EN
         par_ok_q   <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         data      <= data_d;
         valid     <= valid_d;
         frame_err <= ferr_d;
`ifdef RS232_RX_PARITY_EN
         par_ok_q   <= par_ok_d;
         parity_err <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      data_d  = data;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef RS232_RX_PARITY_EN
      par_ok_d = par_ok_q;
      perr_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (rxs == START_LEVEL) state_d = START;
         end
         START: begin
            // A start bit that is gone by mid-bit is treated as a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = (rxs == START_LEVEL) ? DATA : IDLE;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
`ifdef RS232_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
`ifdef RS232_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d    = '0;
               par_ok_d = ~((^shreg_q) ^ rxs);
               state_d  = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rxs == IDLE_LEVEL) begin
                  state_d = IDLE;
`ifdef RS232_RX_PARITY_EN
                  if (par_ok_q) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                  end else begin
                     perr_d = 1'b1;
                  end
`else
                  data_d  = shreg_q;
                  valid_d = 1'b1;
`endif
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // Hold off until the break ends so it reports only once.
            cnt_d = '0;
            if (rxs == IDLE_LEVEL) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rs232_receiver.sv
// Directed bench for rs232_receiver (CLKS_PER_BIT=16, DATA_BITS=8).
// Honours RS232_RX_PARITY_EN when defined.
module tb_rs232_receiver;

   localparam int CPB = 16;
   localparam int DB  = 8;
`ifdef RS232_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FRAME = (DB + 2 + PB) * CPB;
   // rx driven after edge k -> rxs seen by FSM at edge k+3 (T0); stop sampled
   // at T0 + CPB/2 + (DB+1+PB)*CPB, valid high in the cycle after that edge.
   localparam int VLAT  = 3 + CPB / 2 + (DB + 1 + PB) * CPB;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;
`ifdef RS232_RX_PARITY_EN
   logic       parity_err;
`endif

   rs232_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
`ifdef RS232_RX_PARITY_EN
      , .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   int         vcount = 0, vlast_cyc = 0, fcount = 0, flast_cyc = 0, overlap = 0, pcount = 0;
   logic [7:0] vlast_data = 8'h00;

   always @(negedge clk) begin
      if (valid) begin
         vcount++;
         vlast_cyc  = cyc;
         vlast_data = data;
      end
      if (frame_err) begin
         fcount++;
         flast_cyc = cyc;
      end
      if (valid && frame_err) overlap++;
`ifdef RS232_RX_PARITY_EN
      if (parity_err) pcount++;
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      tick(CPB);
   endtask

   task automatic send_start_data(input logic [7:0] b, output int k);
      k = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < DB; i++) drive_bit(b[i]);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, output int k);
      send_start_data(b, k);
`ifdef RS232_RX_PARITY_EN
      drive_bit(^b);
`endif
      drive_bit(stop);
   endtask

`ifdef RS232_RX_PARITY_EN
   task automatic send_frame_badpar(input logic [7:0] b, output int k);
      send_start_data(b, k);
      drive_bit(~(^b));
      drive_bit(1'b1);
   endtask
`endif

   int         k, k1, v0, f0, p0, first_cyc;
   logic [7:0] b;

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      tick(3);
      check("reset_data",  32'(data),      32'h00);
      check("reset_valid", 32'(valid),     32'h0);
      check("reset_ferr",  32'(frame_err), 32'h0);
      check("reset_busy",  32'(busy),      32'h0);
`ifdef RS232_RX_PARITY_EN
      check("reset_perr",  32'(parity_err), 32'h0);
`endif
      rst_n = 1'b1;
      tick(5);

      // single good frame
      v0 = vcount; f0 = fcount;
      send_frame(8'hA5, 1'b1, k);
      tick(4);
      check("t1_vcount", 32'(vcount - v0), 32'd1);
      check("t1_vtime",  32'(vlast_cyc),   32'(k + VLAT));
      check("t1_vdata",  32'(vlast_data),  32'hA5);
      check("t1_data",   32'(data),        32'hA5);
      check("t1_ferr",   32'(fcount - f0), 32'd0);
      check("t1_busy",   32'(busy),        32'h0);

      // start glitch
      v0 = vcount; f0 = fcount;
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      check("t2_busy_hi", 32'(busy), 32'h1);
      tick(8);
      check("t2_busy_lo", 32'(busy), 32'h0);
      tick(20);
      check("t2_vcount", 32'(vcount - v0), 32'd0);
      check("t2_ferr",   32'(fcount - f0), 32'd0);

      // framing error with held break, then recovery
      v0 = vcount; f0 = fcount;
      send_frame(8'h3C, 1'b0, k);
      tick(40);
      check("t3_ferr1",  32'(fcount - f0), 32'd1);
      check("t3_ftime",  32'(flast_cyc),   32'(k + VLAT));
      check("t3_novld",  32'(vcount - v0), 32'd0);
      check("t3_dhold",  32'(data),        32'hA5);
      check("t3_busy_w", 32'(busy),        32'h1);
      rx = 1'b1;
      tick(10);
      check("t3_busy_i", 32'(busy),        32'h0);
      send_frame(8'h3C, 1'b1, k);
      tick(4);
      check("t3_vcount", 32'(vcount - v0), 32'd1);
      check("t3_data",   32'(data),        32'h3C);
      check("t3_ferr2",  32'(fcount - f0), 32'd1);

      // back-to-back frames, no idle gap
      v0 = vcount;
      send_frame(8'h01, 1'b1, k1);
      first_cyc = vlast_cyc;
      check("t4_vdata1", 32'(vlast_data), 32'h01);
      check("t4_vtime1", 32'(first_cyc),  32'(k1 + VLAT));
      send_frame(8'hFF, 1'b1, k);
      tick(4);
      check("t4_vcount", 32'(vcount - v0),           32'd2);
      check("t4_vdata2", 32'(vlast_data),            32'hFF);
      check("t4_spacing", 32'(vlast_cyc - first_cyc), 32'(FRAME));
      check("t4_data",   32'(data),                  32'hFF);

      // asynchronous reset in the middle of data bit 3
      b = 8'h5A;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) drive_bit(b[i]);
      rx = b[3];
      tick(8);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_data",  32'(data),      32'h00);
      check("t5_valid", 32'(valid),     32'h0);
      check("t5_ferr",  32'(frame_err), 32'h0);
      check("t5_busy",  32'(busy),      32'h0);
      rx = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(5);
      check("t5_busy_rel", 32'(busy), 32'h0);
      v0 = vcount;
      send_frame(8'h5A, 1'b1, k);
      tick(4);
      check("t5_vcount", 32'(vcount - v0), 32'd1);
      check("t5_vtime",  32'(vlast_cyc),   32'(k + VLAT));
      check("t5_data",   32'(data),        32'h5A);

`ifdef RS232_RX_PARITY_EN
      // wrong parity, then correct parity
      v0 = vcount; p0 = pcount;
      send_frame_badpar(8'h07, k);
      tick(4);
      check("t6_perr",   32'(pcount - p0), 32'd1);
      check("t6_novld",  32'(vcount - v0), 32'd0);
      check("t6_dhold",  32'(data),        32'h5A);
      send_frame(8'h07, 1'b1, k);
      tick(4);
      check("t6_vcount", 32'(vcount - v0), 32'd1);
      check("t6_data",   32'(data),        32'h07);
      check("t6_perr2",  32'(pcount - p0), 32'd1);
`else
      p0 = pcount;
      check("no_perr", 32'(p0), 32'd0);
`endif

      check("overlap", 32'(overlap), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
